mdu_sequencer: RTL

- Iterative multiply/divide controller for the EX stage.
- Implements MUL (low 32 bits), DIVU and REMU by sequencing the shared 32-bit EX ALU one operation per cycle, using codes ADD 0x0, SUB 0x1 and SLTU 0x9.
- Holds the pipeline stalled until the result is ready.

---
 rtl/mdu_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// Iterative MUL / DIVU / REMU controller that borrows the shared EX-stage ALU
// one operation per cycle and holds the pipeline stalled until the result is ready.
module mdu_sequencer #(
    parameter int DATA_W    = 32,
    parameter bit DIV0_FAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);
    localparam logic [5:0] CNT_FULL = 6'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_CMP,
        S_DIV_SUB,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W-1:0] result_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] rsh;
    logic              cy;
    logic              q_bit;
    logic [DATA_W-1:0] quo_step;
    logic [DATA_W-1:0] acc_step;
    logic              start_is_div;
    logic              op_is_rem;

    // One step of the shift-and-add multiply and restoring divide; the result
    // register is loaded from these on the edge that enters DONE so it is
    // already valid while done is high.
    always_comb begin
        rsh          = {rem[DATA_W-2:0], quo[DATA_W-1]};
        cy           = rem[DATA_W-1];
        q_bit        = cy | (alu_out == '0);
        quo_step     = {quo[DATA_W-2:0], q_bit};
        acc_step     = mplier[0] ? alu_out : acc;
        start_is_div = (op == OP_DIVU) || (op == OP_REMU);
        op_is_rem    = (op_q == OP_REMU);
    end

    always_comb begin
        alu_in1  = '0;
        alu_in2  = '0;
        alu_ctrl = ALU_ADD;
        case (state)
            S_MUL: begin
                alu_in1  = acc;
                alu_in2  = mcand;
                alu_ctrl = ALU_ADD;
            end
            S_DIV_CMP: begin
                alu_in1  = rsh;
                alu_in2  = dvsr;
                alu_ctrl = ALU_SLTU;
            end
            S_DIV_SUB: begin
                alu_in1  = rem;
                alu_in2  = dvsr;
                alu_ctrl = ALU_SUB;
            end
            default: begin
                alu_in1  = '0;
                alu_in2  = '0;
                alu_ctrl = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= rs1;
                        mplier <= rs2;
                        rem    <= '0;
                        quo    <= rs1;
                        dvsr   <= rs2;
                        busy_q <= 1'b1;
                        if (!start_is_div) begin
                            state <= S_MUL;
                        end else if (DIV0_FAST && (rs2 == '0)) begin
                            // RISC-V divide-by-zero: quotient all ones, remainder = dividend
                            quo      <= '1;
                            rem      <= rs1;
                            result_q <= (op == OP_REMU) ? rs1 : '1;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_DIV_CMP;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        result_q <= acc_step;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DIV_CMP: begin
                    rem <= rsh;
                    quo <= quo_step;
                    cnt <= cnt + 6'd1;
                    if (q_bit) begin
                        state <= S_DIV_SUB;
                    end else if (cnt == CNT_LAST) begin
                        result_q <= op_is_rem ? rsh : quo_step;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DIV_SUB: begin
                    rem <= alu_out;
                    if (cnt == CNT_FULL) begin
                        result_q <= op_is_rem ? alu_out : quo;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        state <= S_DIV_CMP;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = ((state == S_IDLE) && start) || (busy_q && !done_q);

endmodule
